// File: rtl/alu_z_stage.sv
// alu_z_stage: result stage downstream of the ALU.
// Latches the op select on a start strobe, waits a per-op settle time for the
// multi-cycle multiply/divide paths, captures the 64-bit ALU result into the
// ZHigh/ZLow register pair with zero/negative flags, and drives Z onto the
// 32-bit bus under the ZLowout/ZHighout enables (ZLowout has priority).
// Optional feature: define ALU_DIV_ZERO_TRAP_EN to trap divide-by-zero
// (skip the settle wait, capture zeros, raise div_err).
module alu_z_stage #(
   parameter int unsigned SETTLE_MUL = 2,
   parameter int unsigned SETTLE_DIV = 4
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [4:0]  select,
   input  logic [31:0] value2,
   input  logic [63:0] alu_result,
   output logic [4:0]  alu_sel,
   output logic        busy,
   output logic        done,
   output logic [31:0] z_high,
   output logic [31:0] z_low,
   input  logic        zhigh_out,
   input  logic        zlow_out,
   output logic [31:0] bus_out,
   output logic        flag_zero,
   output logic        flag_neg,
   output logic        div_err
);

   localparam logic [4:0] OP_DIV = 5'd11;
   localparam logic [4:0] OP_MUL = 5'd12;
   localparam logic [3:0] N_MUL  = 4'(SETTLE_MUL);
   localparam logic [3:0] N_DIV  = 4'(SETTLE_DIV);

`ifdef ALU_DIV_ZERO_TRAP_EN
   localparam bit DIV_TRAP_EN = 1'b1;
`else
   localparam bit DIV_TRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [4:0]  alu_sel_q;
   logic [31:0] z_high_q;
   logic [31:0] z_low_q;
   logic        flag_zero_q;
   logic        flag_neg_q;
   logic        div_err_q;
   logic        busy_q;
   logic        done_q;

   logic [4:0]  op_d;
   logic        div_trap_d;
   logic [3:0]  settle_n_d;
   logic [31:0] z_high_d;
   logic [31:0] z_low_d;
   logic        flag_zero_d;
   logic        flag_neg_d;

   // Capture values and settle count for the current cycle. In IDLE the op
   // being accepted is still on select; later it is the latched copy.
   always_comb begin
      op_d        = (state_q == IDLE) ? select : alu_sel_q;
      div_trap_d  = DIV_TRAP_EN && (select == OP_DIV) && (value2 == '0);

      settle_n_d  = '0;
      case (select)
         OP_DIV:  settle_n_d = N_DIV;
         OP_MUL:  settle_n_d = N_MUL;
         default: settle_n_d = '0;
      endcase
      if (div_trap_d) begin
         settle_n_d = '0;
      end

      z_high_d = alu_result[63:32];
      z_low_d  = alu_result[31:0];

      // Mul/div produce a full 64-bit result; other ops only use the low word.
      if ((op_d == OP_DIV) || (op_d == OP_MUL)) begin
         flag_zero_d = (alu_result == '0);
      end else begin
         flag_zero_d = (alu_result[31:0] == '0);
      end
      // Mul sign lives in bit 63; div sign is the quotient (low word) sign.
      flag_neg_d = (op_d == OP_MUL) ? alu_result[63] : alu_result[31];

      // Trapped divide captures a clean zero regardless of the ALU output.
      if ((state_q == IDLE) && div_trap_d) begin
         z_high_d    = '0;
         z_low_d     = '0;
         flag_zero_d = 1'b1;
         flag_neg_d  = 1'b0;
      end
   end

   // Sequencer: accept, settle countdown, capture Z and flags, done pulse.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         alu_sel_q   <= '0;
         z_high_q    <= '0;
         z_low_q     <= '0;
         flag_zero_q <= 1'b0;
         flag_neg_q  <= 1'b0;
         div_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  alu_sel_q <= select;
                  div_err_q <= div_trap_d;
                  busy_q    <= 1'b1;
                  if (settle_n_d == '0) begin
                     z_high_q    <= z_high_d;
                     z_low_q     <= z_low_d;
                     flag_zero_q <= flag_zero_d;
                     flag_neg_q  <= flag_neg_d;
                     done_q      <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     cnt_q   <= settle_n_d;
                     state_q <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  z_high_q    <= z_high_d;
                  z_low_q     <= z_low_d;
                  flag_zero_q <= flag_zero_d;
                  flag_neg_q  <= flag_neg_d;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Z bus driver: ZLowout wins when both enables are asserted.
   always_comb begin
      bus_out = '0;
      if (zlow_out) begin
         bus_out = z_low_q;
      end else if (zhigh_out) begin
         bus_out = z_high_q;
      end
   end

   assign alu_sel   = alu_sel_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign z_high    = z_high_q;
   assign z_low     = z_low_q;
   assign flag_zero = flag_zero_q;
   assign flag_neg  = flag_neg_q;
   assign div_err   = div_err_q;

endmodule

// File: tb/tb_alu_z_stage.sv
// Self-checking bench for alu_z_stage: table of directed ops plus hand-written
// sequences for reset abort, ignored start while busy, and bus priority.
module tb_alu_z_stage;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [4:0]  select;
   logic [31:0] value2;
   logic [63:0] alu_result;
   logic [4:0]  alu_sel;
   logic        busy;
   logic        done;
   logic [31:0] z_high;
   logic [31:0] z_low;
   logic        zhigh_out;
   logic        zlow_out;
   logic [31:0] bus_out;
   logic        flag_zero;
   logic        flag_neg;
   logic        div_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_z_stage #(.SETTLE_MUL(2), .SETTLE_DIV(4)) dut (
      .clk(clk), .clr(clr), .start(start), .select(select), .value2(value2),
      .alu_result(alu_result), .alu_sel(alu_sel), .busy(busy), .done(done),
      .z_high(z_high), .z_low(z_low), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
      .bus_out(bus_out), .flag_zero(flag_zero), .flag_neg(flag_neg), .div_err(div_err)
   );

   typedef struct {
      logic [4:0]  sel;
      logic [31:0] v2;
      logic [63:0] res;
      int          lat;   // edges from accept edge until done is seen (N+1)
      logic [31:0] zh;
      logic [31:0] zl;
      logic        zf;
      logic        nf;
      logic        de;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Pulse start for one cycle, then count edges (and busy cycles) until done.
   task automatic issue(input logic [4:0] sel, input logic [31:0] v2, input logic [63:0] res,
                        output int lat, output int busy_cyc);
      @(negedge clk);
      select = sel; value2 = v2; alu_result = res; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      busy_cyc = busy ? 1 : 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (busy) busy_cyc++;
      end
   endtask

   initial begin
      int lat;
      int bcyc;
      int pulses;

      vecs[0]  = '{5'd1,  32'd0, 64'h0000_0000_0000_0007, 1, 32'h0,        32'h7,        1'b0, 1'b0, 1'b0};
      vecs[1]  = '{5'd12, 32'd5, 64'hFFFF_FFFF_FFFF_FFFA, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{5'd11, 32'd3, 64'h0000_0001_0000_0004, 5, 32'h1,        32'h4,        1'b0, 1'b0, 1'b0};
      vecs[3]  = '{5'd12, 32'd7, 64'h0000_0000_0000_0000, 3, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
      vecs[4]  = '{5'd12, 32'd7, 64'h0000_0001_0000_0000, 3, 32'h1,        32'h0,        1'b0, 1'b0, 1'b0};
      vecs[5]  = '{5'd1,  32'd0, 64'h0000_0005_0000_0000, 1, 32'h5,        32'h0,        1'b1, 1'b0, 1'b0};
      vecs[6]  = '{5'd2,  32'd0, 64'h0000_0000_8000_0000, 1, 32'h0,        32'h8000_0000, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{5'd0,  32'd0, 64'h0000_0000_0000_0000, 1, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
      vecs[8]  = '{5'd20, 32'd0, 64'h0000_0000_0000_0000, 1, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
      vecs[9]  = '{5'd11, 32'd2, 64'h0000_0000_FFFF_FFFE, 5, 32'h0,        32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{5'd12, 32'd2, 64'h0000_0000_8000_0000, 3, 32'h0,        32'h8000_0000, 1'b0, 1'b0, 1'b0};
`ifdef ALU_DIV_ZERO_TRAP_EN
      vecs[11] = '{5'd11, 32'd0, 64'h0000_0000_0000_0005, 1, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1};
`else
      vecs[11] = '{5'd11, 32'd0, 64'h0000_0000_0000_0005, 5, 32'h0,        32'h5,        1'b0, 1'b0, 1'b0};
`endif
      vecs[12] = '{5'd1,  32'd0, 64'h0000_0000_0000_0009, 1, 32'h0,        32'h9,        1'b0, 1'b0, 1'b0};

      clr = 1'b0; start = 1'b0; select = '0; value2 = '0; alu_result = '0;
      zhigh_out = 1'b0; zlow_out = 1'b0;
      #12;
      check("reset_busy",   64'(busy), 64'd0);
      check("reset_done",   64'(done), 64'd0);
      check("reset_z_high", 64'(z_high), 64'd0);
      check("reset_z_low",  64'(z_low), 64'd0);
      check("reset_alu_sel", 64'(alu_sel), 64'd0);
      check("reset_flags",  64'({flag_zero, flag_neg, div_err}), 64'd0);
      @(negedge clk); clr = 1'b1;

      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].sel, vecs[i].v2, vecs[i].res, lat, bcyc);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("v%0d_busy_cycles", i), 64'(bcyc), 64'(vecs[i].lat));
         check($sformatf("v%0d_z_high", i), 64'(z_high), 64'(vecs[i].zh));
         check($sformatf("v%0d_z_low", i), 64'(z_low), 64'(vecs[i].zl));
         check($sformatf("v%0d_flag_zero", i), 64'(flag_zero), 64'(vecs[i].zf));
         check($sformatf("v%0d_flag_neg", i), 64'(flag_neg), 64'(vecs[i].nf));
         check($sformatf("v%0d_div_err", i), 64'(div_err), 64'(vecs[i].de));
         check($sformatf("v%0d_alu_sel", i), 64'(alu_sel), 64'(vecs[i].sel));
         @(posedge clk); #1;
         check($sformatf("v%0d_done_one_cycle", i), 64'({busy, done}), 64'd0);
      end

      // Bus priority: z_high=0xA, z_low=0xB.
      issue(5'd1, 32'd0, 64'h0000_000A_0000_000B, lat, bcyc);
      @(negedge clk);
      zlow_out = 1'b1; zhigh_out = 1'b1; #1;
      check("bus_both", 64'(bus_out), 64'hB);
      zlow_out = 1'b0; zhigh_out = 1'b1; #1;
      check("bus_high", 64'(bus_out), 64'hA);
      zlow_out = 1'b1; zhigh_out = 1'b0; #1;
      check("bus_low", 64'(bus_out), 64'hB);
      zlow_out = 1'b0; zhigh_out = 1'b0; #1;
      check("bus_none", 64'(bus_out), 64'h0);

      // Div with a second start one cycle later: ignored, alu_sel stays 11,
      // bus shows the previous Z (0xB) while settling.
      @(negedge clk);
      select = 5'd11; value2 = 32'd3; alu_result = 64'h0000_0001_0000_0004; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      select = 5'd1; start = 1'b1; zlow_out = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; select = 5'd11;
      check("ign_alu_sel", 64'(alu_sel), 64'd11);
      check("ign_bus_prev_z", 64'(bus_out), 64'hB);
      lat = 2;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      zlow_out = 1'b0;
      check("ign_latency", 64'(lat), 64'd5);
      check("ign_z", 64'({z_high, z_low}), 64'h0000_0001_0000_0004);
      check("ign_alu_sel_after", 64'(alu_sel), 64'd11);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("ign_no_requeue", 64'({busy, done}), 64'd0);

      // Reset asserted mid-SETTLE of a mul aborts the op.
      @(negedge clk);
      select = 5'd12; value2 = 32'd1; alu_result = 64'h1234_5678_9ABC_DEF0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      clr = 1'b0; #1;
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_z", 64'({z_high, z_low}), 64'd0);
      check("rst_mid_alu_sel", 64'(alu_sel), 64'd0);
      @(negedge clk);
      clr = 1'b1;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("rst_mid_no_done", 64'(pulses), 64'd0);
      check("rst_mid_z_after", 64'({z_high, z_low}), 64'd0);
      check("rst_mid_idle", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
